// File: rtl/floor_request_scheduler.sv
// Call-button latch and SCAN target selector feeding the elevator state machine.
// Optional macro BUTTON_DEBOUNCE_EN inserts a per-button debounce counter after the synchronizer.
module floor_request_scheduler #(
  parameter int NUM_FLOORS      = 10,
  parameter int DWELL_CYCLES    = 10000000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  elev_idle,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, SERVE, DWELL} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              req_reg, req_next;
  logic                    dir_reg, dir_next;
  logic                    door_reg, door_next;
  logic [DWELL_W-1:0]      dwell_cnt_reg, dwell_cnt_next;
  logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
  logic [NUM_FLOORS-1:0]   sync1_reg, sync2_reg, prev_reg;
  logic [NUM_FLOORS-1:0]   btn_level, press, clr_mask;
  logic [NUM_FLOORS-1:0]   cur_onehot, req_onehot;
  logic [3:0]              above_floor, below_floor, sel_floor;
  logic                    above_found, below_found, sel_dir, retarget;

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 || DWELL_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("floor_request_scheduler: parameter out of range");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= call_btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= btn_level;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES);

  // Level flips only after the new value has been seen DEBOUNCE_CYCLES+1 times in a row.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_debounce
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             level_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt_reg <= '0;
        level_reg   <= 1'b0;
      end else if (sync2_reg[gi] == level_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        level_reg   <= sync2_reg[gi];
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end

    assign btn_level[gi] = level_reg;
  end
`else
  assign btn_level = sync2_reg;
`endif

  assign press = btn_level & ~prev_reg;

  // Out-of-range floor numbers simply never match any bit.
  always_comb begin
    cur_onehot = '0;
    req_onehot = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_onehot[i] = (current_floor == 4'(i));
      req_onehot[i] = (req_reg == 4'(i));
    end
  end

  always_comb begin
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_reg[i] && (4'(i) > current_floor)) begin
        above_found = 1'b1;
        above_floor = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_reg[i] && (4'(i) < current_floor)) begin
        below_found = 1'b1;
        below_floor = 4'(i);
      end
    end
  end

  always_comb begin
    sel_floor = current_floor;
    sel_dir   = dir_reg;
    if (dir_reg) begin
      if (above_found) begin
        sel_floor = above_floor;
        sel_dir   = 1'b1;
      end else if (below_found) begin
        sel_floor = below_floor;
        sel_dir   = 1'b0;
      end
    end else begin
      if (below_found) begin
        sel_floor = below_floor;
        sel_dir   = 1'b0;
      end else if (above_found) begin
        sel_floor = above_floor;
        sel_dir   = 1'b1;
      end
    end
  end

  // Nearest request in the sweep direction that lies short of the current target.
  assign retarget = dir_reg ? (above_found && (above_floor < req_reg))
                            : (below_found && (below_floor > req_reg));

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    dir_next       = dir_reg;
    door_next      = door_reg;
    dwell_cnt_next = dwell_cnt_reg;
    clr_mask       = '0;
    case (state_reg)
      IDLE: begin
        req_next = current_floor;
        if (|pending_reg) state_next = SELECT;
      end
      SELECT: begin
        if ((|(pending_reg & cur_onehot)) && elev_idle) begin
          clr_mask       = cur_onehot;
          door_next      = 1'b1;
          dwell_cnt_next = '0;
          state_next     = DWELL;
        end else begin
          req_next   = sel_floor;
          dir_next   = sel_dir;
          state_next = SERVE;
        end
      end
      SERVE: begin
        if ((current_floor == req_reg) && elev_idle) begin
          clr_mask       = req_onehot;
          door_next      = 1'b1;
          dwell_cnt_next = '0;
          state_next     = DWELL;
        end else if (retarget) begin
          req_next = dir_reg ? above_floor : below_floor;
        end
      end
      DWELL: begin
        clr_mask = cur_onehot;
        if (dwell_cnt_reg == DWELL_LAST) begin
          door_next      = 1'b0;
          req_next       = current_floor;
          dwell_cnt_next = '0;
          state_next     = (|pending_reg) ? SELECT : IDLE;
        end else begin
          dwell_cnt_next = dwell_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    pending_next = (pending_reg | press) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_reg       <= '0;
      dir_reg       <= 1'b1;
      door_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
      pending_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      dir_reg       <= dir_next;
      door_reg      <= door_next;
      dwell_cnt_reg <= dwell_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  assign requested_floor = req_reg;
  assign pending         = pending_reg;
  assign dir_up          = dir_reg;
  assign door_open       = door_reg;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a simple car model moving one floor per 8 cycles.
module tb_floor_request_scheduler;

  localparam int NF = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] call_btn = '0;
  logic [3:0]    current_floor;
  logic          elev_idle;
  logic [3:0]    requested_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] car_floor;
  logic       car_idle;
  logic [2:0] step_cnt;
  int         moves;

  assign current_floor = car_floor;
  assign elev_idle     = car_idle;

  floor_request_scheduler #(
    .NUM_FLOORS(NF),
    .DWELL_CYCLES(4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .call_btn(call_btn),
    .current_floor(current_floor),
    .elev_idle(elev_idle),
    .requested_floor(requested_floor),
    .pending(pending),
    .dir_up(dir_up),
    .door_open(door_open)
  );

  always #5 clk = ~clk;

  // Car plant: stays idle one cycle after a new target, then steps every 8 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_floor <= 4'd0;
      car_idle  <= 1'b1;
      step_cnt  <= 3'd0;
      moves     <= 0;
    end else if (car_idle) begin
      if (requested_floor != car_floor) begin
        car_idle <= 1'b0;
        step_cnt <= 3'd0;
      end
    end else if (requested_floor == car_floor) begin
      car_idle <= 1'b1;
    end else if (step_cnt == 3'd7) begin
      step_cnt <= 3'd0;
      moves    <= moves + 1;
      if (requested_floor > car_floor) begin
        car_floor <= car_floor + 4'd1;
        if (car_floor + 4'd1 == requested_floor) car_idle <= 1'b1;
      end else begin
        car_floor <= car_floor - 4'd1;
        if (car_floor - 4'd1 == requested_floor) car_idle <= 1'b1;
      end
    end else begin
      step_cnt <= step_cnt + 3'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    call_btn = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic press(input int f);
    call_btn[f] = 1'b1;
    tick();
    tick();
    call_btn[f] = 1'b0;
  endtask

  task automatic wait_door(input string tag);
    int n;
    n = 0;
    while (!door_open && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(door_open), 32'd1);
  endtask

  task automatic count_door(input string tag);
    int n;
    n = 0;
    while (door_open && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd4);
  endtask

  task automatic wait_car(input string tag, input logic [3:0] f);
    int n;
    n = 0;
    while (car_floor != f && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(car_floor), 32'(f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rises;
    logic prev_door;

    // Reset values, then a simple up call to floor 3
    do_reset();
    check("rst_req", 32'(requested_floor), 32'd0);
    check("rst_pending", 32'(pending), 32'h000);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_door", 32'(door_open), 32'd0);
    press(3);
    check("t1_pend_early", 32'(pending), 32'h000);
    tick();
    check("t1_pend_set", 32'(pending), 32'h008);
    tick();
    tick();
    check("t1_req", 32'(requested_floor), 32'd3);
    check("t1_dir", 32'(dir_up), 32'd1);
    wait_door("t1_door_open");
    check("t1_car", 32'(car_floor), 32'd3);
    check("t1_pend_clr", 32'(pending), 32'h000);
    count_door("t1_dwell_len");
    check("t1_req_after", 32'(requested_floor), 32'd3);
    tick();
    check("t1_idle_req", 32'(requested_floor), 32'd3);

    // Call at the floor the idle car is sitting on
    do_reset();
    press(0);
    tick();
    check("t2_pend_set", 32'(pending), 32'h001);
    tick();
    tick();
    check("t2_door", 32'(door_open), 32'd1);
    check("t2_pend_clr", 32'(pending), 32'h000);
    check("t2_req", 32'(requested_floor), 32'd0);
    count_door("t2_dwell_len");
    check("t2_req_after", 32'(requested_floor), 32'd0);
    check("t2_no_move", 32'(moves), 32'd0);

    // Retarget on the fly: heading to 7, floor 5 pressed while at floor 2
    do_reset();
    press(7);
    repeat (3) tick();
    check("t3_req7", 32'(requested_floor), 32'd7);
    wait_car("t3_at2", 4'd2);
    press(5);
    tick();
    check("t3_pend", 32'(pending), 32'h0A0);
    tick();
    check("t3_retarget", 32'(requested_floor), 32'd5);
    wait_door("t3_door5");
    check("t3_car5", 32'(car_floor), 32'd5);
    check("t3_pend5", 32'(pending), 32'h080);
    count_door("t3_dwell5");
    tick();
    check("t3_resume", 32'(requested_floor), 32'd7);
    wait_door("t3_door7");
    check("t3_car7", 32'(car_floor), 32'd7);
    check("t3_pend7", 32'(pending), 32'h000);

    // Request behind the car waits for the return sweep
    do_reset();
    press(5);
    wait_door("t4_door5");
    count_door("t4_dwell5");
    press(8);
    repeat (3) tick();
    check("t4_req8", 32'(requested_floor), 32'd8);
    press(1);
    tick();
    check("t4_pend", 32'(pending), 32'h102);
    tick();
    check("t4_no_retarget", 32'(requested_floor), 32'd8);
    wait_door("t4_door8");
    check("t4_car8", 32'(car_floor), 32'd8);
    check("t4_pend8", 32'(pending), 32'h002);
    check("t4_dir8", 32'(dir_up), 32'd1);
    count_door("t4_dwell8");
    tick();
    check("t4_req1", 32'(requested_floor), 32'd1);
    check("t4_dir_down", 32'(dir_up), 32'd0);
    wait_door("t4_door1");
    check("t4_car1", 32'(car_floor), 32'd1);
    check("t4_pend1", 32'(pending), 32'h000);

    // Button held across arrival latches once only
    do_reset();
    call_btn[4] = 1'b1;
    rises = 0;
    prev_door = door_open;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (door_open && !prev_door) rises++;
      prev_door = door_open;
    end
    check("t5_served_once", 32'(rises), 32'd1);
    check("t5_car4", 32'(car_floor), 32'd4);
    check("t5_no_relatch", 32'(pending), 32'h000);
    call_btn[4] = 1'b0;
    repeat (5) tick();
    check("t5_released", 32'(pending), 32'h000);
    press(4);
    tick();
    check("t5_repress", 32'(pending), 32'h010);
    tick();
    tick();
    check("t5_door", 32'(door_open), 32'd1);
    count_door("t5_dwell_len");

    // Asynchronous reset while serving floor 6
    do_reset();
    press(6);
    repeat (3) tick();
    check("t6_req6", 32'(requested_floor), 32'd6);
    wait_car("t6_at2", 4'd2);
    press(9);
    tick();
    check("t6_pend", 32'(pending), 32'h240);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(requested_floor), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'h000);
    check("t6_rst_dir", 32'(dir_up), 32'd1);
    check("t6_rst_door", 32'(door_open), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_post_req", 32'(requested_floor), 32'd0);
    check("t6_post_pend", 32'(pending), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
